// File: rtl/writeback_retire_unit_if.sv
// writeback_retire_unit_if: writeback bundle and register-file write ports.
// Ports: WB_* carry one bundle of LANES results, with lane 0 the oldest.
// WB_STALL asks upstream to hold the bundle. RF_* are the per-lane write ports.
interface writeback_retire_unit_if #(
    parameter int XLEN  = 64,
    parameter int LANES = 2
);
    logic [LANES-1:0]      WB_V;
    logic [32*LANES-1:0]   WB_IR;
    logic [XLEN*LANES-1:0] WB_PC;
    logic [XLEN*LANES-1:0] WB_RES;
    logic [LANES-1:0]      WB_REG_WEN;
    logic [LANES-1:0]      WB_W;
    logic [LANES-1:0]      WB_PC_MUX;
    logic [XLEN*LANES-1:0] WB_TARGET;
    logic [LANES-1:0]      WB_EXC;
    logic [4*LANES-1:0]    WB_EXC_CAUSE;
    logic                  WB_STALL;
    logic [LANES-1:0]      RF_WEN;
    logic [5*LANES-1:0]    RF_DR;
    logic [XLEN*LANES-1:0] RF_DATA;
    modport master (
        output WB_V, WB_IR, WB_PC, WB_RES, WB_REG_WEN, WB_W, WB_PC_MUX, WB_TARGET, WB_EXC, WB_EXC_CAUSE,
        input  WB_STALL, RF_WEN, RF_DR, RF_DATA
    );
    modport slave (
        input  WB_V, WB_IR, WB_PC, WB_RES, WB_REG_WEN, WB_W, WB_PC_MUX, WB_TARGET, WB_EXC, WB_EXC_CAUSE,
        output WB_STALL, RF_WEN, RF_DR, RF_DATA
    );
endinterface

// File: rtl/writeback_retire_unit.sv
// writeback_retire_unit: multi-lane in-order retire with redirect, trap and xRET sequencing.
// Ports: CLK/RESET_N (async active-low); wb = writeback bundle and RF write ports;
// PRIV/IRQ/MTVEC/MEPC_IN are trap context; FE_* drive fetch; CSR_WEN/CAUSE_OUT/EPC_OUT
// update MCAUSE/MEPC; INSTRET counts retired instructions.
module writeback_retire_unit #(
    parameter int XLEN   = 64,
    parameter int LANES  = 2,
    parameter bit W_SEXT = 1'b1,
    parameter int CNT_W  = 64
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    writeback_retire_unit_if.slave wb,
    input  logic [1:0]           PRIV,
    input  logic                 IRQ,
    input  logic [XLEN-1:0]      MTVEC,
    input  logic [XLEN-1:0]      MEPC_IN,
    output logic                 FE_PC_MUX,
    output logic [XLEN-1:0]      FE_TARGET,
    output logic                 FE_TRAP_STALL,
    output logic                 CSR_WEN,
    output logic [XLEN-1:0]      CAUSE_OUT,
    output logic [XLEN-1:0]      EPC_OUT,
    output logic [CNT_W-1:0]     INSTRET
);
    typedef enum logic [1:0] {IDLE, TRAP_SAVE, TRAP_REDIR, RET_REDIR} state_t;
    localparam int CW = $clog2(LANES + 1);

    state_t            state_q, state_d;
    logic              csr_wen_q, csr_wen_d;
    logic [XLEN-1:0]   cause_q, cause_d, epc_q, epc_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic              idle, found, k_trap, k_ret;
    logic [XLEN-1:0]   k_pc, k_target, k_cause;
    logic [CW-1:0]     ret_cnt;
    logic [31:0]       ir;
    logic [XLEN-1:0]   res;
    logic              irq_l, ecall, trap, ret, live;

    // Walk lanes oldest first; `found` marks that an older lane already ended the bundle,
    // so every younger lane is squashed.
    always_comb begin
        idle     = state_q == IDLE;
        found    = 1'b0;
        k_trap   = 1'b0;
        k_ret    = 1'b0;
        k_pc     = '0;
        k_target = '0;
        k_cause  = '0;
        ret_cnt  = '0;
        ir       = '0;
        res      = '0;
        irq_l    = 1'b0;
        ecall    = 1'b0;
        trap     = 1'b0;
        ret      = 1'b0;
        live     = 1'b0;
        wb.RF_WEN  = '0;
        wb.RF_DR   = '0;
        wb.RF_DATA = '0;
        for (int i = 0; i < LANES; i++) begin
            ir    = wb.WB_IR[i*32 +: 32];
            res   = wb.WB_RES[i*XLEN +: XLEN];
            irq_l = IRQ && (i == 0);
            ecall = ir == 32'h0000_0073;
            trap  = wb.WB_V[i] & (wb.WB_EXC[i] | ecall | irq_l);
            ret   = wb.WB_V[i] & (ir == 32'h3020_0073 || ir == 32'h1020_0073);
            live  = wb.WB_V[i] & ~found;
            wb.RF_WEN[i]            = idle & live & wb.WB_REG_WEN[i] & ~trap;
            wb.RF_DR[i*5 +: 5]      = idle ? ir[11:7] : 5'd0;
            wb.RF_DATA[i*XLEN +: XLEN] = !idle ? '0 :
                                         wb.WB_W[i] ? {{(XLEN-32){W_SEXT & res[31]}}, res[31:0]} : res;
            if (live & ~trap)
                ret_cnt = ret_cnt + CW'(1);
            if (live & (trap | ret | wb.WB_PC_MUX[i])) begin
                found    = 1'b1;
                k_trap   = trap;
                k_ret    = ret;
                k_pc     = wb.WB_PC[i*XLEN +: XLEN];
                k_target = wb.WB_TARGET[i*XLEN +: XLEN];
                k_cause  = irq_l ? {1'b1, {(XLEN-5){1'b0}}, 4'd11} :
                           ecall ? {{(XLEN-4){1'b0}}, 2'b10, PRIV} :
                                   {{(XLEN-4){1'b0}}, wb.WB_EXC_CAUSE[i*4 +: 4]};
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        csr_wen_d     = 1'b0;
        cause_d       = cause_q;
        epc_d         = epc_q;
        instret_d     = instret_q;
        FE_PC_MUX     = 1'b0;
        FE_TARGET     = '0;
        FE_TRAP_STALL = 1'b0;
        case (state_q)
            IDLE: begin
                instret_d = instret_q + CNT_W'(ret_cnt);
                if (found & k_trap) begin
                    state_d   = TRAP_SAVE;
                    csr_wen_d = 1'b1;
                    cause_d   = k_cause;
                    epc_d     = k_pc;
                end else if (found & k_ret) begin
                    state_d = RET_REDIR;
                end else if (found) begin
                    FE_PC_MUX = 1'b1;
                    FE_TARGET = k_target;
                end
            end
            TRAP_SAVE: begin
                FE_TRAP_STALL = 1'b1;
                state_d       = TRAP_REDIR;
            end
            TRAP_REDIR: begin
                FE_TRAP_STALL = 1'b1;
                FE_PC_MUX     = 1'b1;
                FE_TARGET     = MTVEC;
                state_d       = IDLE;
            end
            default: begin
                FE_TRAP_STALL = 1'b1;
                FE_PC_MUX     = 1'b1;
                FE_TARGET     = MEPC_IN;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            csr_wen_q <= 1'b0;
            cause_q   <= '0;
            epc_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            csr_wen_q <= csr_wen_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            instret_q <= instret_d;
        end
    end

    assign wb.WB_STALL = FE_TRAP_STALL;
    assign CSR_WEN     = csr_wen_q;
    assign CAUSE_OUT   = cause_q;
    assign EPC_OUT     = epc_q;
    assign INSTRET     = instret_q;
endmodule
